// File: rtl/r200_memarb.sv
// r200_memarb: arbiter for the single shared memory port of the r200 pipeline.
// Serialises instruction fetch (if_*) and data (dm_*) accesses onto mem_*.
// Data requests win by default. After STARVE_MAX data grants made while a
// fetch is waiting, the fetch is forced through.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   if_req/addr/kill  fetch request, address, redirect kill
//   if_ack/rdata      fetch completion pulse and registered instruction
//   dm_req/we/addr/wdata  data request bundle
//   dm_ack/rdata      data completion pulse and registered load data
//   mem_req/we/addr/wdata  registered request to memory
//   mem_rdata/ack     memory response
module r200_memarb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_kill,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D
    } state_t;

    state_t        state_q;
    logic [SW-1:0] starve_q;
    logic          kill_q;
    logic          if_ack_q;
    logic [DW-1:0] if_rdata_q;
    logic          dm_ack_q;
    logic [DW-1:0] dm_rdata_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;

    logic win_i;
    logic grant_i;
    logic grant_d;

    // Priority is resolved on the live requests first; the winner is then
    // held off while its own ack is still high, so a requester that keeps
    // its request up through the ack cycle cannot be granted twice and
    // the other side does not jump the queue because of that mask.
    always_comb begin
        win_i   = 1'b0;
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE) begin
            win_i   = if_req && !if_kill && (!dm_req || starve_q == SMAX);
            grant_i = win_i && !if_ack_q;
            grant_d = dm_req && !win_i && !dm_ack_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            kill_q      <= 1'b0;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_ack_q    <= 1'b0;
            dm_rdata_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_i) begin
                        state_q     <= GNT_I;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                        starve_q    <= '0;
                    end else if (grant_d) begin
                        state_q     <= GNT_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we;
                        mem_addr_q  <= dm_addr;
                        mem_wdata_q <= dm_wdata;
                        if (if_req && starve_q != SMAX) begin
                            starve_q <= starve_q + SW'(1);
                        end
                    end
                    if (!if_req) begin
                        starve_q <= '0;
                    end
                end
                GNT_I: begin
                    if (if_kill) begin
                        kill_q <= 1'b1;
                    end
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        kill_q    <= 1'b0;
                        // A redirect seen at any point of the access,
                        // including the completion edge, drops the data.
                        if (!kill_q && !if_kill) begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= mem_rdata;
                        end
                    end
                end
                GNT_D: begin
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        dm_ack_q  <= 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_q <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_ack    = dm_ack_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_r200_memarb.sv
// tb_r200_memarb: directed bench for r200_memarb.
// Cycle vector table plus hand sequences for arbitration, reset and ack reuse.
module tb_r200_memarb;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_kill, if_ack;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    r200_memarb #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        logic        ifr, ifk;
        logic [31:0] iad;
        logic        dmr, dwe;
        logic [31:0] dad, dwd;
        logic        mack;
        logic [31:0] mrd;
        logic [131:0] exp;
    } vec_t;

    vec_t tbl[21];

    function automatic logic [131:0] ex(input logic mreq, input logic mwe,
                                        input logic [31:0] maddr, input logic [31:0] mwd,
                                        input logic iack, input logic [31:0] ird,
                                        input logic dack, input logic [31:0] drd);
        return {mreq, mwe, maddr, mwd, iack, ird, dack, drd};
    endfunction

    function automatic vec_t mk(input logic ifr, input logic ifk, input logic [31:0] iad,
                                input logic dmr, input logic dwe, input logic [31:0] dad,
                                input logic [31:0] dwd, input logic mack, input logic [31:0] mrd,
                                input logic [131:0] e);
        vec_t v;
        v.ifr = ifr; v.ifk = ifk; v.iad = iad;
        v.dmr = dmr; v.dwe = dwe; v.dad = dad; v.dwd = dwd;
        v.mack = mack; v.mrd = mrd; v.exp = e;
        return v;
    endfunction

    function automatic logic [131:0] obs();
        return {mem_req, mem_we, mem_addr, mem_wdata, if_ack, if_rdata, dm_ack, dm_rdata};
    endfunction

    task automatic chk(input string nm, input logic [131:0] act, input logic [131:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] DA = 32'h0000_2000;
    localparam logic [31:0] IA = 32'h0000_1000;

    logic [31:0] grants[$];
    logic [31:0] order[10];
    logic        prev;

    initial begin
        rst = 1'b1;
        if_req = 0; if_kill = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        mem_ack = 0; mem_rdata = '0;

        // lone load, store, killed fetch, normal fetch, idle mem_ack, idle kill
        tbl[0]  = mk(0,0,0, 0,0,0,0, 0,0, ex(0,0,0,0, 0,0, 0,0));
        tbl[1]  = mk(0,0,0, 1,0,32'h100,0, 0,0, ex(1,0,32'h100,0, 0,0, 0,0));
        tbl[2]  = mk(0,0,0, 1,0,32'h100,0, 0,0, ex(1,0,32'h100,0, 0,0, 0,0));
        tbl[3]  = mk(0,0,0, 1,0,32'h100,0, 1,DB, ex(0,0,32'h100,0, 0,0, 1,DB));
        tbl[4]  = mk(0,0,0, 0,0,0,0, 0,0, ex(0,0,32'h100,0, 0,0, 0,DB));
        tbl[5]  = mk(0,0,0, 0,0,0,0, 0,0, ex(0,0,32'h100,0, 0,0, 0,DB));
        tbl[6]  = mk(0,0,0, 1,1,32'h20,32'h12345678, 0,0,
                     ex(1,1,32'h20,32'h12345678, 0,0, 0,DB));
        tbl[7]  = mk(0,0,0, 1,1,32'h20,32'h12345678, 0,0,
                     ex(1,1,32'h20,32'h12345678, 0,0, 0,DB));
        tbl[8]  = mk(0,0,0, 1,1,32'h20,32'h12345678, 1,32'hAAAA5555,
                     ex(0,1,32'h20,32'h12345678, 0,0, 1,DB));
        tbl[9]  = mk(0,0,0, 0,0,0,0, 0,0, ex(0,1,32'h20,32'h12345678, 0,0, 0,DB));
        tbl[10] = mk(1,0,32'h40, 0,0,0,0, 0,0, ex(1,0,32'h40,0, 0,0, 0,DB));
        tbl[11] = mk(1,1,32'h40, 0,0,0,0, 0,0, ex(1,0,32'h40,0, 0,0, 0,DB));
        tbl[12] = mk(0,0,0, 0,0,0,0, 0,0, ex(1,0,32'h40,0, 0,0, 0,DB));
        tbl[13] = mk(0,0,0, 0,0,0,0, 1,32'h11111111, ex(0,0,32'h40,0, 0,0, 0,DB));
        tbl[14] = mk(0,0,0, 0,0,0,0, 0,0, ex(0,0,32'h40,0, 0,0, 0,DB));
        tbl[15] = mk(1,0,32'h80, 0,0,0,0, 0,0, ex(1,0,32'h80,0, 0,0, 0,DB));
        tbl[16] = mk(1,0,32'h80, 0,0,0,0, 1,32'h13, ex(0,0,32'h80,0, 1,32'h13, 0,DB));
        tbl[17] = mk(0,0,0, 0,0,0,0, 0,0, ex(0,0,32'h80,0, 0,32'h13, 0,DB));
        tbl[18] = mk(0,0,0, 0,0,0,0, 1,32'hFFFF, ex(0,0,32'h80,0, 0,32'h13, 0,DB));
        tbl[19] = mk(1,1,32'hC0, 0,0,0,0, 0,0, ex(0,0,32'h80,0, 0,32'h13, 0,DB));
        tbl[20] = mk(0,0,0, 0,0,0,0, 0,0, ex(0,0,32'h80,0, 0,32'h13, 0,DB));

        order = '{DA, DA, DA, DA, IA, DA, DA, DA, DA, IA};

        repeat (2) @(negedge clk);
        chk("reset_outputs", obs(), 132'd0);
        rst = 1'b0;

        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            if_req = tbl[k].ifr; if_kill = tbl[k].ifk; if_addr = tbl[k].iad;
            dm_req = tbl[k].dmr; dm_we = tbl[k].dwe;
            dm_addr = tbl[k].dad; dm_wdata = tbl[k].dwd;
            mem_ack = tbl[k].mack; mem_rdata = tbl[k].mrd;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", k), obs(), tbl[k].exp);
        end

        // both requesters continuously active, memory answers after 1 cycle
        @(negedge clk);
        dm_req = 1; dm_we = 0; dm_addr = DA; dm_wdata = '0;
        if_req = 1; if_kill = 0; if_addr = IA;
        mem_ack = 0; prev = 0;
        for (int c = 0; c < 200 && grants.size() < 10; c++) begin
            @(negedge clk);
            if (mem_req && !prev) grants.push_back(mem_addr);
            prev = mem_req;
            if (mem_ack) mem_ack = 0;
            else if (mem_req) begin
                mem_ack = 1;
                mem_rdata = mem_addr ^ 32'h5A5A;
            end
        end
        dm_req = 0; if_req = 0;
        chk("starve_grant_count", 132'(grants.size()), 132'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < grants.size())
                chk($sformatf("starve_order%0d", i), 132'(grants[i]), 132'(order[i]));
        end
        @(negedge clk);
        mem_ack = 0;
        repeat (2) @(negedge clk);
        chk("starve_drain_idle", 132'(mem_req), 132'd0);

        // reset while a data access waits for memory
        dm_req = 1; dm_we = 0; dm_addr = 32'h300;
        @(posedge clk); #1;
        chk("rst_pre_memreq", 132'({mem_req, mem_addr}), 132'({1'b1, 32'h300}));
        @(negedge clk);
        rst = 1;
        #1;
        chk("rst_async_memreq", 132'({mem_req, dm_ack}), 132'd0);
        @(negedge clk);
        rst = 0; dm_req = 0;
        @(negedge clk);
        mem_ack = 1; mem_rdata = 32'h77777777;
        @(posedge clk); #1;
        chk("rst_late_ack", 132'({mem_req, dm_ack, dm_rdata}), 132'd0);
        @(negedge clk);
        mem_ack = 0;
        dm_req = 1; dm_addr = 32'h304;
        @(posedge clk); #1;
        chk("rst_next_grant", 132'({mem_req, mem_addr}), 132'({1'b1, 32'h304}));
        @(negedge clk);
        mem_ack = 1; mem_rdata = 32'h0000CAFE;
        @(posedge clk); #1;
        chk("rst_next_ack", 132'({dm_ack, dm_rdata}), 132'({1'b1, 32'h0000CAFE}));

        // dm_req kept high through its own ack cycle
        @(negedge clk);
        mem_ack = 0;
        @(posedge clk); #1;
        chk("hold_ack_no_regrant", 132'({mem_req, dm_ack}), 132'd0);
        @(negedge clk);
        dm_req = 0;
        @(posedge clk); #1;
        chk("hold_after_drop", 132'({mem_req, dm_ack}), 132'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
